// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter among
// NUM_REQ byte-stream requesters; a grant ends on req_last or after MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          burst_cut
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST) + 1;
  localparam int unsigned NR = NUM_REQ;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state;
  logic [IW-1:0]          owner;
  logic [IW-1:0]          last_owner;
  logic [CW-1:0]          count;
  logic [DATA_WIDTH-1:0]  data_q;

  logic [DATA_WIDTH-1:0]  slices [NUM_REQ];
  logic [DATA_WIDTH-1:0]  owner_data;
  logic                   owner_valid;
  logic                   owner_last;
  logic                   fire;
  logic [IW-1:0]          pick;
  logic                   pick_ok;
  logic [IW:0]            cand;

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      slices[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_data  = slices[owner];
  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign busy        = (state == XFER);
  assign fire        = tx_valid & tx_ready;

  // Search upward from last_owner+1 with wrap; the first hit wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = {1'b0, last_owner} + (IW+1)'(k);
      if (cand >= (IW+1)'(NR)) cand = cand - (IW+1)'(NR);
      if (!pick_ok && req_valid[cand[IW-1:0]]) begin
        pick    = cand[IW-1:0];
        pick_ok = 1'b1;
      end
    end
  end

  // Data path is combinational from the owner; tx_data falls back to the
  // last transferred byte so a non-owner byte can never appear.
  always_comb begin
    tx_valid  = 1'b0;
    req_ready = '0;
    tx_data   = data_q;
    if (state == XFER && ena && owner_valid) begin
      tx_valid         = 1'b1;
      tx_data          = owner_data;
      req_ready[owner] = tx_ready;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= LAST_IDX;
      count      <= '0;
      data_q     <= '0;
      burst_cut  <= 1'b0;
    end else begin
      burst_cut <= 1'b0;
      if (ena) begin
        case (state)
          IDLE: begin
            if (pick_ok) begin
              state <= XFER;
              owner <= pick;
              grant <= ONE << pick;
              count <= '0;
            end
          end
          XFER: begin
            if (fire) begin
              data_q <= owner_data;
              if (owner_last || count == CNT_MAX) begin
                state      <= IDLE;
                grant      <= '0;
                last_owner <= owner;
                burst_cut  <= !owner_last;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requesters replay byte lists, every
// UART handshake and per-cycle grant is logged and compared to fixed sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ena = 1'b1;
  logic [31:0] req_data = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [3:0]  grant;
  logic        busy;
  logic        burst_cut;

  uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(16)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant(grant), .busy(busy), .burst_cut(burst_cut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem   [4][32];
  logic       lastf [4][32];
  int         len   [4];
  int         pos   [4];

  logic [7:0] hs_data [$];
  logic [3:0] hs_grant [$];
  logic [3:0] gtrace [$];
  logic       ctrace [$];
  logic [3:0] fired;

  logic [3:0] s_grant, s_rr;
  logic [7:0] s_txd;
  logic       s_txv, s_busy, s_cut;

  localparam logic [3:0] EXP2 [10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0};
  localparam logic [7:0] DAT2 [6]  = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
  localparam logic [3:0] ORD3 [4]  = '{4'h1, 4'h2, 4'h4, 4'h8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (pos[i] < len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = mem[i][pos[i]];
        req_last[i]        = lastf[i][pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input logic l);
    mem[r][len[r]]   = b;
    lastf[r][len[r]] = l;
    len[r]++;
  endtask

  // One clock: snapshot outputs at the falling edge, advance sources after the rising edge.
  task automatic cycle();
    @(negedge clk);
    s_grant = grant; s_rr = req_ready; s_txd = tx_data;
    s_txv = tx_valid; s_busy = busy; s_cut = burst_cut;
    gtrace.push_back(grant);
    ctrace.push_back(burst_cut);
    if (tx_valid && tx_ready) begin
      hs_data.push_back(tx_data);
      hs_grant.push_back(grant);
    end
    fired = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (fired[i]) pos[i]++;
    drive();
  endtask

  task automatic clear_logs();
    hs_data.delete(); hs_grant.delete(); gtrace.delete(); ctrace.delete();
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    ena      = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin len[i] = 0; pos[i] = 0; end
    drive();
    cycle();
    cycle();
    reset_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cut_total;

    // Reset values and a single 3-byte message from requester 0
    do_reset();
    chk("rst_grant", 32'(s_grant), 0);
    chk("rst_txv", 32'(s_txv), 0);
    chk("rst_txd", 32'(s_txd), 0);
    chk("rst_rr", 32'(s_rr), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_cut", 32'(s_cut), 0);
    add_byte(0, 8'h41, 1'b0); add_byte(0, 8'h42, 1'b0); add_byte(0, 8'h43, 1'b1);
    drive();
    cycle();
    chk("t1_req_seen_grant", 32'(s_grant), 0);
    chk("t1_req_seen_txv", 32'(s_txv), 0);
    cycle();
    chk("t1_grant", 32'(s_grant), 32'h1);
    chk("t1_busy", 32'(s_busy), 1);
    chk("t1_d0", 32'(s_txd), 32'h41);
    chk("t1_rr0", 32'(s_rr), 32'h1);
    cycle();
    chk("t1_d1", 32'(s_txd), 32'h42);
    cycle();
    chk("t1_d2", 32'(s_txd), 32'h43);
    chk("t1_rr2", 32'(s_rr), 32'h1);
    cycle();
    chk("t1_end_grant", 32'(s_grant), 0);
    chk("t1_end_busy", 32'(s_busy), 0);
    chk("t1_end_rr", 32'(s_rr), 0);
    chk("t1_hs_count", 32'(hs_data.size()), 3);

    // Contention between requesters 0,1,2
    do_reset();
    add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hA1, 1'b1);
    add_byte(1, 8'hB0, 1'b0); add_byte(1, 8'hB1, 1'b1);
    add_byte(2, 8'hC0, 1'b0); add_byte(2, 8'hC1, 1'b1);
    drive();
    for (int c = 0; c < 10; c++) cycle();
    for (int c = 0; c < 10; c++) chk($sformatf("t2_grant_c%0d", c), 32'(gtrace[c]), 32'(EXP2[c]));
    chk("t2_hs_count", 32'(hs_data.size()), 6);
    for (int n = 0; n < 6 && n < hs_data.size(); n++)
      chk($sformatf("t2_data%0d", n), 32'(hs_data[n]), 32'(DAT2[n]));

    // Round-robin fairness: three 1-byte messages per requester
    do_reset();
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < 4; r++) add_byte(r, 8'(16*r + m), 1'b1);
    drive();
    for (int c = 0; c < 25; c++) cycle();
    chk("t3_hs_count", 32'(hs_data.size()), 12);
    for (int n = 0; n < 12 && n < hs_data.size(); n++) begin
      chk($sformatf("t3_grant%0d", n), 32'(hs_grant[n]), 32'(ORD3[n % 4]));
      chk($sformatf("t3_data%0d", n), 32'(hs_data[n]), 32'(16*(n % 4) + n / 4));
    end
    for (int c = 0; c < 25; c += 2) chk($sformatf("t3_idle_c%0d", c), 32'(gtrace[c]), 0);

    // Burst cut after 16 bytes from requester 3
    do_reset();
    for (int b = 0; b < 20; b++) add_byte(3, 8'(b), b == 19);
    drive();
    for (int c = 0; c < 23; c++) cycle();
    chk("t4_hs_count", 32'(hs_data.size()), 20);
    for (int n = 0; n < 20 && n < hs_data.size(); n++) begin
      chk($sformatf("t4_data%0d", n), 32'(hs_data[n]), 32'(n));
      chk($sformatf("t4_grant%0d", n), 32'(hs_grant[n]), 32'h8);
    end
    chk("t4_cut_cycle", 32'(ctrace[17]), 1);
    chk("t4_release_grant", 32'(gtrace[17]), 0);
    chk("t4_regrant", 32'(gtrace[18]), 32'h8);
    cut_total = 0;
    foreach (ctrace[i]) if (ctrace[i]) cut_total++;
    chk("t4_cut_total", 32'(cut_total), 1);
    chk("t4_end_grant", 32'(gtrace[22]), 0);

    // Backpressure, then enable low, mid-message from requester 2
    do_reset();
    for (int b = 0; b < 4; b++) add_byte(2, 8'(8'h50 + b), b == 3);
    drive();
    cycle(); cycle(); cycle();
    chk("t5_pre_hs", 32'(hs_data.size()), 2);
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk($sformatf("t5_stall_rr%0d", c), 32'(s_rr), 0);
      chk($sformatf("t5_stall_grant%0d", c), 32'(s_grant), 32'h4);
      chk($sformatf("t5_stall_txd%0d", c), 32'(s_txd), 32'h52);
    end
    chk("t5_stall_hs", 32'(hs_data.size()), 2);
    tx_ready = 1'b1;
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk($sformatf("t5_dis_txv%0d", c), 32'(s_txv), 0);
      chk($sformatf("t5_dis_rr%0d", c), 32'(s_rr), 0);
      chk($sformatf("t5_dis_grant%0d", c), 32'(s_grant), 32'h4);
      chk($sformatf("t5_dis_txd%0d", c), 32'(s_txd), 32'h51);
    end
    chk("t5_dis_hs", 32'(hs_data.size()), 2);
    ena = 1'b1;
    cycle(); cycle(); cycle();
    chk("t5_hs_count", 32'(hs_data.size()), 4);
    for (int n = 0; n < 4 && n < hs_data.size(); n++)
      chk($sformatf("t5_data%0d", n), 32'(hs_data[n]), 32'(8'h50 + n));
    chk("t5_end_grant", 32'(s_grant), 0);

    // Reset mid-message, then requesters 1 and 0 compete
    do_reset();
    for (int b = 0; b < 4; b++) add_byte(1, 8'(8'h60 + b), b == 3);
    drive();
    cycle(); cycle(); cycle();
    chk("t6_pre_hs", 32'(hs_data.size()), 2);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_txv", 32'(tx_valid), 0);
    chk("t6_rst_txd", 32'(tx_data), 0);
    chk("t6_rst_rr", 32'(req_ready), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cut", 32'(burst_cut), 0);
    for (int i = 0; i < 4; i++) begin len[i] = 0; pos[i] = 0; end
    add_byte(1, 8'h70, 1'b0); add_byte(1, 8'h71, 1'b1);
    add_byte(0, 8'h80, 1'b0); add_byte(0, 8'h81, 1'b1);
    drive();
    cycle();
    reset_n = 1'b1;
    clear_logs();
    for (int c = 0; c < 7; c++) cycle();
    chk("t6_first_grant", 32'(gtrace[1]), 32'h1);
    chk("t6_hs_count", 32'(hs_data.size()), 4);
    if (hs_data.size() == 4) begin
      chk("t6_d0", 32'(hs_data[0]), 32'h80);
      chk("t6_d1", 32'(hs_data[1]), 32'h81);
      chk("t6_d2", 32'(hs_data[2]), 32'h70);
      chk("t6_d3", 32'(hs_data[3]), 32'h71);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte-stream requesters, for example the TX FIFO, a status reporter and an echo path. Arbitration is round-robin at message granularity. Once a requester is granted, it keeps the transmitter until it sends a byte flagged last, or until MAX_BURST bytes have been sent. The block sits between the requesters and the uart tx_data/tx_valid/tx_ready interface.

Parameters:
DATA_WIDTH, 8, byte width on all data ports.
NUM_REQ, 4, number of requesters; legal range 2..8.
MAX_BURST, 16, maximum bytes per grant before forced release; legal range ≥ 1.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous reset, active-low.
ena  input  1  global enable; low freezes the block.
req_data  input  NUM_REQ*DATA_WIDTH  requester bytes; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
req_valid  input  NUM_REQ  requester i has a byte.
req_last  input  NUM_REQ  requester i's current byte ends its message.
req_ready  output  NUM_REQ  byte on requester i accepted this cycle.
tx_data  output  DATA_WIDTH  byte to the UART transmitter.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  UART transmitter can accept a byte.
grant  output  NUM_REQ  one-hot current owner; all zero when idle.
busy  output  1  high in XFER.
burst_cut  output  1  one-cycle pulse when a grant is released by MAX_BURST rather than req_last.

Behaviour:
- Handshakes:
  - Requester side: a transfer occurs in a cycle with req_valid[i] && req_ready[i].
  - UART side: a transfer occurs in a cycle with tx_valid && tx_ready.
  - The two sides always coincide.
- Reset (asynchronous, all registers):
  - state = IDLE, grant = 0, byte count = 0.
  - Last-owner pointer = NUM_REQ-1, so requester 0 has first priority.
  - Outputs: tx_valid = 0, tx_data = 0, req_ready = 0, busy = 0, burst_cut = 0.
- State IDLE:
  - tx_valid = 0, req_ready = 0, grant = 0.
  - If ena and any req_valid: pick the first valid index searching upward, with wrap, from last-owner+1.
  - Load grant one-hot, clear count, move to XFER.
  - Arbitration latency: grant is visible the cycle after a request is seen in IDLE.
- State XFER, owner g (combinational path):
  - tx_data = req_data slice g.
  - tx_valid = req_valid[g] & ena.
  - req_ready[g] = tx_ready & ena & req_valid[g]; all other req_ready bits = 0.
  - tx_data holds its last registered value when tx_valid is low; it must never show a non-owner's byte.
- On each handshake in XFER:
  - If req_last[g]: release and go to IDLE.
  - Else if count == MAX_BURST-1: release, go to IDLE, and pulse burst_cut the next cycle.
  - Else: count++.
  - A release sets last-owner = g and clears grant.
  - The earliest next grant is two cycles after the final handshake; the IDLE cycle is mandatory.
- Owner drops req_valid mid-message: grant holds indefinitely. There is no idle timeout; only req_last or MAX_BURST releases the grant.
- Non-owner requests during XFER: ignored, and req_ready stays 0 for them. They are considered at the next IDLE.
- req_last on a byte with no handshake: no effect.
- ena low:
  - tx_valid = 0, req_ready = 0.
  - state, grant, count and pointer are held; no arbitration occurs.
  - Resumes unchanged when ena returns high.
- Reset mid-message:
  - Outputs return to reset values immediately.
  - The partial message is abandoned, and the pointer returns to NUM_REQ-1.
- MAX_BURST = 1: every byte releases; burst_cut pulses after every byte without req_last.
- The count width is clog2(MAX_BURST)+1, and the count never wraps.

Test Plan:
- Single message:
  - Stimulus: reset, then req 0 sends 0x41, 0x42, 0x43 with last on 0x43; tx_ready always 1.
  - Response: grant = 0001 one cycle after the request; tx_data sequence 41, 42, 43; req_ready[0] high for 3 cycles; then IDLE with grant = 0 and busy = 0.
- Contention:
  - Stimulus: reqs 0, 1 and 2 each hold a 2-byte message from the same cycle.
  - Response: grants in order 0001, 0010, 0100; each message is contiguous; exactly one idle cycle between messages.
- Round-robin fairness:
  - Stimulus: all 4 requesters present 1-byte messages continuously.
  - Response: grant order 0, 1, 2, 3, 0, 1, …; no requester is granted twice before the others are served.
- Burst cut:
  - Stimulus: MAX_BURST = 16; req 3 streams 20 bytes 0x00..0x13 with last only on 0x13.
  - Response: bytes 0x00..0x0F sent, then burst_cut pulses once and the grant is released; after the other requesters' turns (none here), bytes 0x10..0x13 are sent in a new grant; no burst_cut at the end.
- Backpressure and enable:
  - Stimulus: mid-message, tx_ready is low for 5 cycles, then ena is low for 3 cycles.
  - Response: no req_ready or tx_valid while stalled or disabled; grant and count are held; the byte order is intact after resuming.
- Reset mid-message:
  - Stimulus: reset_n asserted low after req 1 has sent 2 of 4 bytes; then reqs 1 and 0 both request.
  - Response: all outputs are 0 during reset; after release, req 0 is granted first (pointer reset).
